// File: rtl/branch_sequencer.sv
// Multi-cycle branch resolution controller: accepts one branch, waits for forwarded
// operands, resolves the condition, redirects fetch on taken and holds a flush window.
module branch_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       branchop,
  input  logic [31:0]      pc,
  input  logic [31:0]      imm,
  input  logic             ops_valid,
  input  logic [31:0]      dataS1,
  input  logic [31:0]      dataS2,
  input  logic             kill,
  output logic             stall,
  output logic             resolve_valid,
  output logic             resolve_taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count,
  output logic [1:0]       fsm_state
);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE and is withheld while kill is asserted.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_OPS = 2'd1,
    RESOLVE  = 2'd2,
    FLUSH    = 2'd3
  } state_t;

  localparam int FC_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES);

  state_t            state_q, state_d;
  logic [3:0]        op_q;
  logic [31:0]       pc_q;
  logic [31:0]       imm_q;
  logic [31:0]       s1_q;
  logic [31:0]       s2_q;
  logic [FC_W-1:0]   flush_cnt_q;
  logic              cond;
  logic              taken;
  logic              accept;
  logic              ops_take;
  logic              resolve_commit;

  // Condition is computed from registered operands only.
  always_comb begin
    cond = 1'b0;
    case (op_q[2:0])
      3'b000:  cond = (s1_q == s2_q);
      3'b001:  cond = (s1_q != s2_q);
      3'b010:  cond = ($signed(s1_q) <  $signed(s2_q));
      3'b011:  cond = (s1_q <  s2_q);
      3'b100:  cond = ($signed(s1_q) >= $signed(s2_q));
      3'b101:  cond = (s1_q >= s2_q);
      default: cond = 1'b0;
    endcase
  end

  assign taken          = op_q[3] & cond;
  assign accept         = (state_q == IDLE) & req_valid & ~kill;
  assign ops_take       = (state_q == WAIT_OPS) & ops_valid & ~kill;
  assign resolve_commit = (state_q == RESOLVE) & ~kill;

  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    flush          = 1'b0;
    stall          = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        req_ready = ~kill;
        if (req_valid) state_d = WAIT_OPS;
      end
      WAIT_OPS: begin
        if (ops_valid) state_d = RESOLVE;
      end
      RESOLVE: begin
        resolve_valid  = 1'b1;
        resolve_taken  = taken;
        redirect_valid = taken;
        redirect_pc    = taken ? (pc_q + imm_q) : 32'd0;
        state_d        = (taken && (FLUSH_CYCLES > 0)) ? FLUSH : IDLE;
      end
      FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q <= FC_W'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Abort overrides everything: no pulses leave a killed RESOLVE cycle.
    if (kill) begin
      state_d        = IDLE;
      resolve_valid  = 1'b0;
      resolve_taken  = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= 4'd0;
      pc_q  <= 32'd0;
      imm_q <= 32'd0;
      s1_q  <= 32'd0;
      s2_q  <= 32'd0;
    end else begin
      if (accept) begin
        op_q  <= branchop;
        pc_q  <= pc;
        imm_q <= imm;
      end
      if (ops_take) begin
        s1_q <= dataS1;
        s2_q <= dataS2;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt_q <= '0;
    end else if ((state_q == RESOLVE) && (state_d == FLUSH)) begin
      flush_cnt_q <= FLUSH_LOAD;
    end else if ((state_q == FLUSH) && (flush_cnt_q != '0)) begin
      flush_cnt_q <= flush_cnt_q - FC_W'(1);
    end
  end

  // Performance counters wrap naturally and survive kill.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count <= '0;
      taken_count  <= '0;
    end else if (resolve_commit) begin
      if (op_q[3]) branch_count <= branch_count + CNT_W'(1);
      if (taken)   taken_count  <= taken_count + CNT_W'(1);
    end
  end

  assign fsm_state = state_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: two instances (FLUSH_CYCLES=2/CNT_W=16 and
// FLUSH_CYCLES=0/CNT_W=4), a per-cycle expectation queue and counter model.
module tb_branch_sequencer;

  localparam int K_NONE  = 0;
  localparam int K_WAIT  = 1;
  localparam int K_RES   = 2;
  localparam int K_FLUSH = 3;
  localparam int EW      = 38;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel_b = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  branchop = 4'd0;
  logic [31:0] pc = 32'd0;
  logic [31:0] imm = 32'd0;
  logic        ops_valid = 1'b0;
  logic [31:0] dataS1 = 32'd0;
  logic [31:0] dataS2 = 32'd0;
  logic        kill = 1'b0;

  logic        a_ready, a_stall, a_rv, a_rt, a_dv, a_flush;
  logic [31:0] a_dpc;
  logic [15:0] a_bc, a_tc;
  logic [1:0]  a_state;
  logic        b_ready, b_stall, b_rv, b_rt, b_dv, b_flush;
  logic [31:0] b_dpc;
  logic [3:0]  b_bc, b_tc;
  logic [1:0]  b_state;

  logic        m_ready, m_stall, m_rv, m_rt, m_dv, m_flush;
  logic [31:0] m_dpc;

  logic [EW-1:0] exp_q[$];
  logic [15:0]   exp_bc_a = 16'd0, exp_tc_a = 16'd0;
  logic [3:0]    exp_bc_b = 4'd0,  exp_tc_b = 4'd0;
  logic [31:0]   last_redir = 32'd0;
  logic          chk_en = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  branch_sequencer #(.FLUSH_CYCLES(2), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & ~sel_b), .req_ready(a_ready),
    .branchop(branchop), .pc(pc), .imm(imm),
    .ops_valid(ops_valid & ~sel_b), .dataS1(dataS1), .dataS2(dataS2),
    .kill(kill & ~sel_b), .stall(a_stall),
    .resolve_valid(a_rv), .resolve_taken(a_rt),
    .redirect_valid(a_dv), .redirect_pc(a_dpc), .flush(a_flush),
    .branch_count(a_bc), .taken_count(a_tc), .fsm_state(a_state)
  );

  branch_sequencer #(.FLUSH_CYCLES(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid & sel_b), .req_ready(b_ready),
    .branchop(branchop), .pc(pc), .imm(imm),
    .ops_valid(ops_valid & sel_b), .dataS1(dataS1), .dataS2(dataS2),
    .kill(kill & sel_b), .stall(b_stall),
    .resolve_valid(b_rv), .resolve_taken(b_rt),
    .redirect_valid(b_dv), .redirect_pc(b_dpc), .flush(b_flush),
    .branch_count(b_bc), .taken_count(b_tc), .fsm_state(b_state)
  );

  assign m_ready = sel_b ? b_ready : a_ready;
  assign m_stall = sel_b ? b_stall : a_stall;
  assign m_rv    = sel_b ? b_rv    : a_rv;
  assign m_rt    = sel_b ? b_rt    : a_rt;
  assign m_dv    = sel_b ? b_dv    : a_dv;
  assign m_flush = sel_b ? b_flush : a_flush;
  assign m_dpc   = sel_b ? b_dpc   : a_dpc;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // record layout: {ready, stall, resolve_valid, resolve_taken, redirect_valid, flush, redirect_pc}
  task automatic push(input logic rdy, input logic stl, input logic rv, input logic rt,
                      input logic dv, input logic fl, input logic [31:0] dpc);
    exp_q.push_back({rdy, stl, rv, rt, dv, fl, dpc});
  endtask

  function automatic logic cond_of(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd2:    return $signed(a) < $signed(b);
      3'd3:    return a < b;
      3'd4:    return $signed(a) >= $signed(b);
      3'd5:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  // driver: one branch transaction, pushing what each cycle must look like
  task automatic do_branch(input logic ib, input logic [3:0] op, input logic [31:0] bpc,
                           input logic [31:0] bimm, input logic [31:0] s1, input logic [31:0] s2,
                           input int delay, input int kmode, input logic idle_ops);
    int   fl_len;
    logic tk;
    fl_len = ib ? 0 : 2;
    tk     = op[3] & cond_of(op[2:0], s1, s2);
    sel_b     = ib;
    req_valid = 1'b1;
    branchop  = op;
    pc        = bpc;
    imm       = bimm;
    ops_valid = idle_ops;
    dataS1    = ~s1;
    dataS2    = s1;
    push(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    req_valid = 1'b0;
    branchop  = 4'($urandom);
    pc        = $urandom;
    imm       = $urandom;
    ops_valid = 1'b0;
    if (kmode == K_WAIT) begin
      kill = 1'b1;
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      kill = 1'b0;
      return;
    end
    for (int i = 0; i < delay; i++) begin
      dataS1 = $urandom;
      dataS2 = $urandom;
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
    end
    ops_valid = 1'b1;
    dataS1    = s1;
    dataS2    = s2;
    push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    ops_valid = 1'b0;
    dataS1    = $urandom;
    dataS2    = $urandom;
    if (kmode == K_RES) begin
      kill = 1'b1;
      push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
      tick();
      kill = 1'b0;
      return;
    end
    push(1'b0, 1'b1, 1'b1, tk, tk, 1'b0, tk ? (bpc + bimm) : 32'd0);
    tick();
    if (ib) begin
      if (op[3]) exp_bc_b = exp_bc_b + 4'd1;
      if (tk)    exp_tc_b = exp_tc_b + 4'd1;
    end else begin
      if (op[3]) exp_bc_a = exp_bc_a + 16'd1;
      if (tk)    exp_tc_a = exp_tc_a + 16'd1;
    end
    if (tk) begin
      for (int j = 0; j < fl_len; j++) begin
        if (kmode == K_FLUSH) begin
          kill = 1'b1;
          push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
          tick();
          kill = 1'b0;
          return;
        end
        push(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        tick();
      end
    end
  endtask

  // scoreboard: every cycle, the active instance against the queue, counters against the model
  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] act;
    if (chk_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = {1'b1, 37'd0};
      act = {m_ready, m_stall, m_rv, m_rt, m_dv, m_flush, m_dpc};
      if (m_dv) last_redir = m_dpc;
      check("cycle_outputs", 64'(act), 64'(e));
      check("branch_count_a", 64'(a_bc), 64'(exp_bc_a));
      check("taken_count_a",  64'(a_tc), 64'(exp_tc_a));
      check("branch_count_b", 64'(b_bc), 64'(exp_bc_b));
      check("taken_count_b",  64'(b_tc), 64'(exp_tc_b));
    end
  end

  initial begin
    tick();
    tick();
    check("rst_ready",   64'(a_ready), 64'd1);
    check("rst_stall",   64'(a_stall), 64'd0);
    check("rst_rv",      64'(a_rv),    64'd0);
    check("rst_dpc",     64'(a_dpc),   64'd0);
    check("rst_flush",   64'(a_flush), 64'd0);
    check("rst_bc",      64'(a_bc),    64'd0);
    check("rst_tc_b",    64'(b_tc),    64'd0);
    reset  = 1'b0;
    chk_en = 1'b1;
    tick();

    // not-taken BEQ, immediate operands
    do_branch(1'b0, 4'b1000, 32'h0000_0040, 32'h10, 32'd5, 32'd6, 0, K_NONE, 1'b0);
    tick();
    check("beq_nt_bc", 64'(a_bc), 64'd1);
    check("beq_nt_tc", 64'(a_tc), 64'd0);

    // signed vs unsigned less-than
    last_redir = 32'd0;
    do_branch(1'b0, 4'b1010, 32'h100, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 0, K_NONE, 1'b0);
    check("blt_redirect", 64'(last_redir), 64'h0F0);
    check("blt_ready_after_flush", 64'(a_ready), 64'd1);
    do_branch(1'b0, 4'b1011, 32'h100, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd1, 0, K_NONE, 1'b0);

    // operand wait then non-branch op
    do_branch(1'b0, 4'b0001, 32'h200, 32'h20, 32'd3, 32'd9, 4, K_NONE, 1'b0);

    // PC wrap
    last_redir = 32'd0;
    do_branch(1'b0, 4'b1001, 32'hFFFF_FFFC, 32'd8, 32'd1, 32'd2, 0, K_NONE, 1'b0);
    check("bne_wrap_redirect", 64'(last_redir), 64'h4);

    // remaining conditions, including both sides of each compare
    do_branch(1'b0, 4'b1100, 32'h300, 32'h40, 32'd1, 32'hFFFF_FFFF, 1, K_NONE, 1'b0);
    do_branch(1'b0, 4'b1100, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0, K_NONE, 1'b0);
    do_branch(1'b0, 4'b1101, 32'h300, 32'h40, 32'd1, 32'hFFFF_FFFF, 0, K_NONE, 1'b0);
    do_branch(1'b0, 4'b1001, 32'h300, 32'h40, 32'd7, 32'd7, 2, K_NONE, 1'b0);
    do_branch(1'b0, 4'b1000, 32'h310, 32'h80, 32'd7, 32'd7, 0, K_NONE, 1'b0);
    do_branch(1'b0, 4'b1110, 32'h300, 32'h40, 32'd7, 32'd7, 0, K_NONE, 1'b0);
    do_branch(1'b0, 4'b1111, 32'h300, 32'h40, 32'd1, 32'd2, 0, K_NONE, 1'b0);
    do_branch(1'b0, 4'b1011, 32'h400, 32'h4, 32'd1, 32'd2, 0, K_NONE, 1'b0);

    // operands offered in the accept cycle must be ignored
    do_branch(1'b0, 4'b1000, 32'h500, 32'h8, 32'd11, 32'd12, 2, K_NONE, 1'b1);

    // kill in WAIT_OPS, RESOLVE (taken) and FLUSH
    do_branch(1'b0, 4'b1000, 32'h600, 32'h8, 32'd1, 32'd1, 0, K_WAIT, 1'b0);
    do_branch(1'b0, 4'b1000, 32'h600, 32'h8, 32'd1, 32'd1, 0, K_RES, 1'b0);
    do_branch(1'b0, 4'b1000, 32'h600, 32'h8, 32'd1, 32'd1, 0, K_FLUSH, 1'b0);
    do_branch(1'b0, 4'b1001, 32'h700, 32'h8, 32'd1, 32'd2, 0, K_NONE, 1'b0);

    // kill in IDLE blocks an offered request
    req_valid = 1'b1;
    kill      = 1'b1;
    branchop  = 4'b1000;
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    tick();
    req_valid = 1'b0;
    kill      = 1'b0;
    tick();

    // zero-length flush window, then taken-count wrap at 4 bits
    last_redir = 32'd0;
    do_branch(1'b1, 4'b1101, 32'h800, 32'h10, 32'd7, 32'd7, 0, K_NONE, 1'b0);
    check("bgeu_f0_redirect", 64'(last_redir), 64'h810);
    for (int i = 0; i < 15; i++) begin
      logic [31:0] v;
      v = $urandom;
      do_branch(1'b1, 4'b1000, $urandom, $urandom, v, v, i % 2, K_NONE, 1'b0);
    end
    tick();
    check("wrap_taken_b",  64'(b_tc), 64'd0);
    check("wrap_branch_b", 64'(b_bc), 64'd0);
    sel_b = 1'b0;
    tick();

    // asynchronous reset in the middle of FLUSH
    chk_en    = 1'b0;
    req_valid = 1'b1;
    branchop  = 4'b1010;
    pc        = 32'h100;
    imm       = 32'hFFFF_FFF0;
    tick();
    req_valid = 1'b0;
    ops_valid = 1'b1;
    dataS1    = 32'hFFFF_FFFF;
    dataS2    = 32'd1;
    tick();
    ops_valid = 1'b0;
    tick();
    check("pre_reset_flush", 64'(a_flush), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_flush", 64'(a_flush), 64'd0);
    check("async_reset_stall", 64'(a_stall), 64'd0);
    check("async_reset_ready", 64'(a_ready), 64'd1);
    check("async_reset_bc",    64'(a_bc),    64'd0);
    tick();
    reset    = 1'b0;
    exp_bc_a = 16'd0;
    exp_tc_a = 16'd0;
    exp_bc_b = 4'd0;
    exp_tc_b = 4'd0;
    chk_en   = 1'b1;
    tick();
    do_branch(1'b0, 4'b1001, 32'h900, 32'h4, 32'd5, 32'd6, 1, K_NONE, 1'b0);
    tick();
    tick();
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
